debug_snapshot_buffer: RTL and testbench
========================================

Name: debug_snapshot_buffer

Overview:
- Multi-entry history buffer for the MIPS debug unit. It captures a configurable number of 32-bit pipeline-state fields (PC, adder PC, fetched instruction, cycle count, branch, register data, control bits, ...) on each step.
- It keeps the last CANT_SNAPSHOTS snapshots and streams any selected snapshot word by word to the UART debug path over a valid/ready handshake.
- It is the parametrised successor of the single-snapshot, control-indexed field selector, adding history depth, trace/stop modes and a streamed readout.

Parameters:
- LONGITUD_DATO, 32, width of each field and of o_dato.
- CANT_CAMPOS, 8, fields per snapshot (>=1).
- CANT_SNAPSHOTS, 4, history depth; must be a power of two, >=2.

Ports:
- i_clock  in  1  system clock.
- i_soft_reset  in  1  synchronous reset, active-high.
- i_capture_enable  in  1  pipeline advanced this cycle; capture i_campos.
- i_campos  in  CANT_CAMPOS*LONGITUD_DATO  flattened fields; field k = bits [k*LONGITUD_DATO +: LONGITUD_DATO].
- i_modo  in  1  0 = circular trace (overwrite oldest), 1 = stop when full.
- i_clear  in  1  empty the buffer.
- i_read_req  in  1  request readout of snapshot i_read_sel.
- i_read_sel  in  clogb2(CANT_SNAPSHOTS-1)  relative age; 0 = newest.
- i_dato_ready  in  1  consumer accepts o_dato this cycle.
- o_dato  out  LONGITUD_DATO  current readout word.
- o_dato_valid  out  1  o_dato is valid.
- o_last  out  1  o_dato is field CANT_CAMPOS-1.
- o_busy  out  1  stream in progress.
- o_error  out  1  one-cycle pulse: request rejected.
- o_count  out  clogb2(CANT_SNAPSHOTS)  stored snapshots, 0..CANT_SNAPSHOTS.
- o_full  out  1  o_count == CANT_SNAPSHOTS.
- o_overflow  out  1  sticky: a snapshot was dropped or overwritten.

Behaviour:
- Reset (i_soft_reset=1 at a clock edge): all outputs 0, wr_ptr=0, count=0, FSM=IDLE. Storage contents are not reset; unwritten slots are never readable.
- Capture, one edge, when i_capture_enable=1:
  - Writes all fields to slot wr_ptr. wr_ptr increments mod CANT_SNAPSHOTS. count increments, saturating at CANT_SNAPSHOTS.
  - Full in circular mode: the oldest snapshot is overwritten, count stays, o_overflow is set.
  - Full in stop mode: the capture is dropped, wr_ptr and count are unchanged, o_overflow is set.
- Physical slot of age r: (wr_ptr - 1 - r) mod CANT_SNAPSHOTS, computed with natural wrap of the pointer width.
- i_clear:
  - Sets count=0, wr_ptr=0 and o_overflow=0 next cycle.
  - Aborts any stream: FSM goes to IDLE, o_dato_valid/o_busy go to 0.
  - Clear and capture in the same cycle: clear wins and the capture is discarded.
- FSM IDLE:
  - Sampling i_read_req=1 with i_read_sel < count latches the physical slot rd_slot, sets field index=0 and moves to STREAM.
  - The next cycle shows o_dato = field 0, with o_dato_valid=1 and o_busy=1.
  - Latency from request edge to first valid word: 1 cycle.
- Rejected request: i_read_sel >= count (including count=0). o_error pulses 1 cycle later, FSM stays IDLE, no data is produced.
- FSM STREAM:
  - o_dato and o_valid are held stable while i_dato_ready=0.
  - On an edge with i_dato_ready=1, the field index increments and the next word appears the following cycle.
  - o_last=1 while the field index is CANT_CAMPOS-1.
  - Acceptance of the last word returns the FSM to IDLE; o_dato_valid, o_busy and o_last are 0 the next cycle.
  - i_read_req in STREAM is ignored, with no o_error.
- Capture during STREAM is allowed and updates wr_ptr/count normally.
  - Exception: if the target slot equals rd_slot, the capture is dropped and o_overflow is set. The streamed snapshot is never corrupted.
- Width rules: o_count is one bit wider than the pointer. Fields are stored unmodified; no sign extension.

Decomposition:
- Package debug_pkg holds:
  - the clogb2 function;
  - FSM state encoding (IDLE, STREAM);
  - field index constants (CAMPO_PC=0, CAMPO_ADDER_PC=1, CAMPO_INSTRUCCION=2, CAMPO_CICLOS=3, CAMPO_BRANCH=4, CAMPO_DATA_A=5, CAMPO_DATA_B=6, CAMPO_CONTROL=7).
- Sub-module debug_snapshot_mem:
  - CANT_SNAPSHOTS x CANT_CAMPOS register array.
  - One full-snapshot write port and one registered word read port (slot, field).
  - The top level keeps the pointers, count, flags and FSM.

Test Plan:
- Reset, then 3 captures with field k of capture j = 16*j+k (j=1..3), then read sel=0 with ready=1 constantly -> words 0x30..0x37 on consecutive cycles, o_last on 0x37, o_count=3, o_overflow=0.
- Circular mode, 6 captures (j=1..6) -> o_full=1, o_overflow=1; sel=3 streams 0x30..0x37 and sel=0 streams 0x60..0x67.
- Stop mode, 6 captures -> o_count=4, o_overflow=1; sel=0 streams 0x40..0x47 (captures 5 and 6 dropped).
- Backpressure: toggle i_dato_ready 1,0,0,1,... -> each word held while ready=0; exactly 8 accepted words, no duplicates or skips.
- Read sel=2 with o_count=1 -> o_error pulse 1 cycle after request, o_dato_valid stays 0; i_clear mid-stream -> o_dato_valid=0 and o_count=0 next cycle.
- Circular, full, streaming sel=3 (oldest, slot == wr_ptr) while capturing once -> capture dropped, o_overflow=1, streamed words unchanged, o_count=4.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared definitions for the debug snapshot history buffer:
// sizing helper, readout FSM states and pipeline field indices.
package debug_pkg;

    // Returns the number of bits needed to hold the value depth.
    function automatic int clogb2(input int depth);
        int r;
        int d;
        r = 0;
        d = depth;
        while (d > 0) begin
            r = r + 1;
            d = d >> 1;
        end
        return r;
    endfunction

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } estado_t;

    localparam int CAMPO_PC          = 0;
    localparam int CAMPO_ADDER_PC    = 1;
    localparam int CAMPO_INSTRUCCION = 2;
    localparam int CAMPO_CICLOS      = 3;
    localparam int CAMPO_BRANCH      = 4;
    localparam int CAMPO_DATA_A      = 5;
    localparam int CAMPO_DATA_B      = 6;
    localparam int CAMPO_CONTROL     = 7;

endpackage

// File: rtl/debug_snapshot_mem.sv
// Snapshot storage: full-snapshot write port and one registered
// word read port addressed by (slot, field).
module debug_snapshot_mem
    import debug_pkg::*;
#(
    parameter int LONGITUD_DATO  = 32,
    parameter int CANT_CAMPOS    = 8,
    parameter int CANT_SNAPSHOTS = 4,
    parameter int PTR_W          = 2,
    parameter int IDX_W          = 3
) (
    input  logic                                   i_clock,
    input  logic                                   i_we,
    input  logic [PTR_W-1:0]                       i_wr_slot,
    input  logic [CANT_CAMPOS*LONGITUD_DATO-1:0]   i_wr_campos,
    input  logic [PTR_W-1:0]                       i_rd_slot,
    input  logic [IDX_W-1:0]                       i_rd_campo,
    output logic [LONGITUD_DATO-1:0]               o_dato
);

    logic [LONGITUD_DATO-1:0] r_mem [CANT_SNAPSHOTS][CANT_CAMPOS];
    logic [LONGITUD_DATO-1:0] r_dato;

    always_ff @(posedge i_clock) begin
        if (i_we) begin
            for (int k = 0; k < CANT_CAMPOS; k++) begin
                r_mem[i_wr_slot][k] <= i_wr_campos[k*LONGITUD_DATO +: LONGITUD_DATO];
            end
        end
        r_dato <= r_mem[i_rd_slot][i_rd_campo];
    end

    assign o_dato = r_dato;

endmodule

// File: rtl/debug_snapshot_buffer.sv
// Multi-snapshot debug history buffer with trace/stop capture
// modes and a word-by-word valid/ready readout stream.
module debug_snapshot_buffer
    import debug_pkg::*;
#(
    parameter int LONGITUD_DATO  = 32,
    parameter int CANT_CAMPOS    = 8,
    parameter int CANT_SNAPSHOTS = 4
) (
    input  logic                                       i_clock,
    input  logic                                       i_soft_reset,
    input  logic                                       i_capture_enable,
    input  logic [CANT_CAMPOS*LONGITUD_DATO-1:0]       i_campos,
    input  logic                                       i_modo,
    input  logic                                       i_clear,
    input  logic                                       i_read_req,
    input  logic [clogb2(CANT_SNAPSHOTS-1)-1:0]        i_read_sel,
    input  logic                                       i_dato_ready,
    output logic [LONGITUD_DATO-1:0]                   o_dato,
    output logic                                       o_dato_valid,
    output logic                                       o_last,
    output logic                                       o_busy,
    output logic                                       o_error,
    output logic [clogb2(CANT_SNAPSHOTS)-1:0]          o_count,
    output logic                                       o_full,
    output logic                                       o_overflow
);

    localparam int PTR_W = clogb2(CANT_SNAPSHOTS-1);
    localparam int CNT_W = clogb2(CANT_SNAPSHOTS);
    localparam int IDX_W = (CANT_CAMPOS > 1) ? clogb2(CANT_CAMPOS-1) : 1;

    estado_t                  r_estado, w_estado_n;
    logic [PTR_W-1:0]         r_wr_ptr, r_rd_slot, w_rd_slot_n;
    logic [PTR_W-1:0]         w_req_slot, w_prot_slot;
    logic [CNT_W-1:0]         r_count;
    logic [IDX_W-1:0]         r_idx, w_idx_n;
    logic                     r_overflow, r_error;
    logic                     w_full, w_sel_ok, w_req_ok, w_req_bad;
    logic                     w_prot, w_hit, w_we, w_last;
    logic [LONGITUD_DATO-1:0] w_mem_dato;

    assign w_full     = (r_count == CNT_W'(CANT_SNAPSHOTS));
    assign w_req_slot = r_wr_ptr - PTR_W'(1) - i_read_sel;
    assign w_sel_ok   = (CNT_W'(i_read_sel) < r_count);
    assign w_req_ok   = (r_estado == IDLE) && i_read_req && !i_clear && w_sel_ok;
    assign w_req_bad  = (r_estado == IDLE) && i_read_req && !i_clear && !w_sel_ok;
    assign w_last     = (r_idx == IDX_W'(CANT_CAMPOS-1));

    // The slot being streamed (or about to be) must never be overwritten.
    assign w_prot      = (r_estado == STREAM) || w_req_ok;
    assign w_prot_slot = (r_estado == STREAM) ? r_rd_slot : w_req_slot;
    assign w_hit       = w_prot && (r_wr_ptr == w_prot_slot);
    assign w_we        = i_capture_enable && !i_clear && !w_hit && !(w_full && i_modo);

    always_comb begin
        w_estado_n  = r_estado;
        w_rd_slot_n = r_rd_slot;
        w_idx_n     = r_idx;
        if (i_clear) begin
            w_estado_n = IDLE;
        end else begin
            case (r_estado)
                IDLE: begin
                    if (w_req_ok) begin
                        w_estado_n  = STREAM;
                        w_rd_slot_n = w_req_slot;
                        w_idx_n     = '0;
                    end
                end
                STREAM: begin
                    if (i_dato_ready) begin
                        if (w_last) w_estado_n = IDLE;
                        else        w_idx_n    = r_idx + IDX_W'(1);
                    end
                end
                default: w_estado_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_soft_reset) begin
            r_estado  <= IDLE;
            r_rd_slot <= '0;
            r_idx     <= '0;
        end else begin
            r_estado  <= w_estado_n;
            r_rd_slot <= w_rd_slot_n;
            r_idx     <= w_idx_n;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_soft_reset) begin
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_error <= w_req_bad;
            if (i_clear) begin
                r_wr_ptr   <= '0;
                r_count    <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_we) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                    if (!w_full) r_count <= r_count + CNT_W'(1);
                end
                if (i_capture_enable && (w_full || w_hit)) r_overflow <= 1'b1;
            end
        end
    end

    // Read address follows next-state so the word lands with valid.
    debug_snapshot_mem #(
        .LONGITUD_DATO  (LONGITUD_DATO),
        .CANT_CAMPOS    (CANT_CAMPOS),
        .CANT_SNAPSHOTS (CANT_SNAPSHOTS),
        .PTR_W          (PTR_W),
        .IDX_W          (IDX_W)
    ) u_mem (
        .i_clock     (i_clock),
        .i_we        (w_we),
        .i_wr_slot   (r_wr_ptr),
        .i_wr_campos (i_campos),
        .i_rd_slot   (w_rd_slot_n),
        .i_rd_campo  (w_idx_n),
        .o_dato      (w_mem_dato)
    );

    assign o_dato_valid = (r_estado == STREAM);
    assign o_busy       = (r_estado == STREAM);
    assign o_last       = (r_estado == STREAM) && w_last;
    assign o_dato       = o_dato_valid ? w_mem_dato : '0;
    assign o_error      = r_error;
    assign o_count      = r_count;
    assign o_full       = w_full;
    assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_debug_snapshot_buffer.sv
// Scoreboard bench for debug_snapshot_buffer: directed captures,
// streamed readouts checked by a decoupled negedge monitor.
module tb_debug_snapshot_buffer;

    localparam int LD = 32;
    localparam int CC = 8;
    localparam int CS = 4;

    typedef struct {
        logic [LD-1:0] d;
        logic          l;
    } exp_t;

    logic              clk = 1'b0;
    logic              i_soft_reset = 1'b1;
    logic              i_capture_enable = 1'b0;
    logic [CC*LD-1:0]  i_campos = '0;
    logic              i_modo = 1'b0;
    logic              i_clear = 1'b0;
    logic              i_read_req = 1'b0;
    logic [1:0]        i_read_sel = '0;
    logic              i_dato_ready = 1'b1;
    logic [LD-1:0]     o_dato;
    logic              o_dato_valid, o_last, o_busy, o_error;
    logic [2:0]        o_count;
    logic              o_full, o_overflow;

    int   n_pass = 0;
    int   n_tot  = 0;
    int   n_acc  = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    debug_snapshot_buffer #(
        .LONGITUD_DATO  (LD),
        .CANT_CAMPOS    (CC),
        .CANT_SNAPSHOTS (CS)
    ) dut (
        .i_clock          (clk),
        .i_soft_reset     (i_soft_reset),
        .i_capture_enable (i_capture_enable),
        .i_campos         (i_campos),
        .i_modo           (i_modo),
        .i_clear          (i_clear),
        .i_read_req       (i_read_req),
        .i_read_sel       (i_read_sel),
        .i_dato_ready     (i_dato_ready),
        .o_dato           (o_dato),
        .o_dato_valid     (o_dato_valid),
        .o_last           (o_last),
        .o_busy           (o_busy),
        .o_error          (o_error),
        .o_count          (o_count),
        .o_full           (o_full),
        .o_overflow       (o_overflow)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    // Monitor: every accepted word is popped and compared.
    always @(negedge clk) begin
        if (o_dato_valid && i_dato_ready) begin
            exp_t e;
            n_acc++;
            if (q.size() == 0) begin
                chk("unexpected_word", o_dato, 32'hdeadbeef);
            end else begin
                e = q.pop_front();
                chk("word", o_dato, e.d);
                chk("last", 32'(o_last), 32'(e.l));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_campos(input int j);
        for (int k = 0; k < CC; k++) i_campos[k*LD +: LD] = 32'(16*j + k);
    endtask

    task automatic capture(input int j);
        set_campos(j);
        i_capture_enable = 1'b1;
        tick();
        i_capture_enable = 1'b0;
    endtask

    task automatic do_clear();
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
    endtask

    task automatic do_read(input int sel, input int base, input bit bp,
                           input int cap_at, input int cap_j);
        int p;
        int acc0;
        exp_t e;
        for (int k = 0; k < CC; k++) begin
            e.d = 32'(base + k);
            e.l = (k == CC-1);
            q.push_back(e);
        end
        acc0 = n_acc;
        i_read_sel = 2'(sel);
        i_read_req = 1'b1;
        tick();
        i_read_req = 1'b0;
        chk("first_valid", 32'(o_dato_valid), 32'd1);
        p = 0;
        while (o_busy && p < 200) begin
            i_dato_ready = bp ? (p % 3 == 0) : 1'b1;
            if (p == cap_at) begin
                set_campos(cap_j);
                i_capture_enable = 1'b1;
            end else begin
                i_capture_enable = 1'b0;
            end
            tick();
            p++;
        end
        i_capture_enable = 1'b0;
        i_dato_ready = 1'b1;
        chk("stream_done", 32'(o_busy), 32'd0);
        chk("accepted", 32'(n_acc - acc0), 32'd8);
        chk("queue_empty", 32'(q.size()), 32'd0);
        q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        tick();
        tick();
        i_soft_reset = 1'b0;
        chk("rst_count", 32'(o_count), 32'd0);
        chk("rst_valid", 32'(o_dato_valid), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_full", 32'(o_full), 32'd0);
        chk("rst_ovf", 32'(o_overflow), 32'd0);
        chk("rst_err", 32'(o_error), 32'd0);

        // three captures, newest readout
        for (int j = 1; j <= 3; j++) capture(j);
        chk("cnt3", 32'(o_count), 32'd3);
        do_read(0, 'h30, 1'b0, -1, 0);
        chk("ovf3", 32'(o_overflow), 32'd0);

        // circular mode overwrite
        do_clear();
        i_modo = 1'b0;
        for (int j = 1; j <= 6; j++) capture(j);
        chk("circ_full", 32'(o_full), 32'd1);
        chk("circ_ovf", 32'(o_overflow), 32'd1);
        chk("circ_cnt", 32'(o_count), 32'd4);
        do_read(3, 'h30, 1'b0, -1, 0);
        do_read(0, 'h60, 1'b0, -1, 0);

        // stop mode drops captures when full
        do_clear();
        chk("clr_ovf", 32'(o_overflow), 32'd0);
        i_modo = 1'b1;
        for (int j = 1; j <= 6; j++) capture(j);
        chk("stop_cnt", 32'(o_count), 32'd4);
        chk("stop_ovf", 32'(o_overflow), 32'd1);
        do_read(0, 'h40, 1'b0, -1, 0);
        do_read(3, 'h10, 1'b1, -1, 0);

        // rejected request, clear mid-stream
        do_clear();
        i_modo = 1'b0;
        capture(1);
        chk("one_cnt", 32'(o_count), 32'd1);
        i_read_sel = 2'd2;
        i_read_req = 1'b1;
        tick();
        i_read_req = 1'b0;
        chk("err_pulse", 32'(o_error), 32'd1);
        chk("err_novalid", 32'(o_dato_valid), 32'd0);
        tick();
        chk("err_end", 32'(o_error), 32'd0);
        chk("err_idle", 32'(o_busy), 32'd0);
        i_dato_ready = 1'b0;
        i_read_sel = 2'd0;
        i_read_req = 1'b1;
        tick();
        i_read_req = 1'b0;
        chk("ms_valid", 32'(o_dato_valid), 32'd1);
        chk("ms_word0", o_dato, 32'h10);
        tick();
        tick();
        chk("ms_hold", o_dato, 32'h10);
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        chk("ms_clr_valid", 32'(o_dato_valid), 32'd0);
        chk("ms_clr_count", 32'(o_count), 32'd0);
        i_dato_ready = 1'b1;

        // oldest slot protected from capture while streamed
        for (int j = 1; j <= 4; j++) capture(j);
        chk("prot_ovf0", 32'(o_overflow), 32'd0);
        chk("prot_full", 32'(o_full), 32'd1);
        do_read(3, 'h10, 1'b0, 2, 9);
        chk("prot_ovf", 32'(o_overflow), 32'd1);
        chk("prot_cnt", 32'(o_count), 32'd4);
        do_read(0, 'h40, 1'b0, -1, 0);
        do_read(3, 'h10, 1'b0, -1, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
